// File: rtl/data_mem_resp_pkg.sv
// ============================================================
// Package : data_mem_resp_pkg
// Brief   : Shared types and constants for the data memory responder.
// Rev     : 1.0
// ============================================================
`default_nettype none

package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  typedef logic [31:0] word_t;

  localparam int unsigned WAIT_STATES_DEFAULT = 2;
  localparam word_t       OOR_READ_DATA       = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/data_mem_resp_if.sv
// ============================================================
// Interface : data_mem_resp_if
// Brief     : M-stage CPU <-> data memory request/response bundle.
// Rev       : 1.0
// ============================================================
`default_nettype none

interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic  mem_read_M;
  logic  mem_write_M;
  word_t alu_out_M;
  word_t write_data_M;
  word_t read_data_M;
  logic  data_mem_ack_M;
  logic  bus_err;

  modport master (
    output mem_read_M, mem_write_M, alu_out_M, write_data_M,
    input  read_data_M, data_mem_ack_M, bus_err
  );

  modport slave (
    input  mem_read_M, mem_write_M, alu_out_M, write_data_M,
    output read_data_M, data_mem_ack_M, bus_err
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_resp_sram_1p.sv
// ============================================================
// Module : sram_1p
// Brief  : Single-port synchronous word RAM, registered read, no reset.
// Rev    : 1.0
// ============================================================
`default_nettype none

module sram_1p #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read-before-write: a same-cycle write is visible on the following access.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_resp.sv
// ============================================================
// Module : data_mem_resp
// Brief  : Fixed-latency data memory responder with sticky range error.
// Rev    : 1.0
// ============================================================
`default_nettype none

module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_resp_if.slave  bus
);

  localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  word_t                 wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  oor_q, oor_d;
  word_t                 rdata_q, rdata_d;
  logic                  berr_q, berr_d;

  logic                  w_req;
  logic                  w_oor;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_in_ack;
  logic                  w_load_ack;
  logic                  w_sram_we;
  logic [ADDR_WIDTH-1:0] w_sram_addr;
  word_t                 w_sram_rdata;
  word_t                 w_load_data;

  assign w_req = bus.mem_read_M | bus.mem_write_M;
  assign w_oor = (bus.alu_out_M >> (ADDR_WIDTH + 2)) != 32'd0;
  assign w_idx = bus.alu_out_M[ADDR_WIDTH+1:2];

  // Reset in the ACK cycle suppresses both the ack and the write.
  assign w_in_ack    = (state_q == S_ACK) && !reset;
  assign w_load_ack  = w_in_ack && rd_q && !wr_q;
  assign w_sram_we   = w_in_ack && wr_q && !oor_q;
  assign w_load_data = oor_q ? OOR_READ_DATA : w_sram_rdata;

  // In IDLE the live address goes straight to the RAM so its registered
  // output is ready by ACK even with zero wait states.
  assign w_sram_addr = (state_q == S_IDLE) ? w_idx : idx_q;

  sram_1p #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_sram (
    .clk     (clk),
    .we_i    (w_sram_we),
    .addr_i  (w_sram_addr),
    .wdata_i (wdata_q),
    .rdata_o (w_sram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    oor_d   = oor_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          idx_d   = w_idx;
          wdata_d = bus.write_data_M;
          wr_d    = bus.mem_write_M;
          rd_d    = bus.mem_read_M;
          oor_d   = w_oor;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = c_WAIT_LOAD;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (w_load_ack) begin
          rdata_d = w_load_data;
        end
        if (oor_q) begin
          berr_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.data_mem_ack_M = w_in_ack;
  assign bus.read_data_M    = w_load_ack ? w_load_data : rdata_q;
  assign bus.bus_err        = berr_q | (w_in_ack && oor_q);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_resp.sv
// ============================================================
// Module : tb_data_mem_resp
// Brief  : Self-checking bench for data_mem_resp (2 and 0 wait states).
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_data_mem_resp;

  logic        clk;
  logic        reset;
  logic        sel;      // 0: two-wait-state DUT, 1: zero-wait-state DUT
  logic        req_rd, req_wr;
  logic [31:0] req_addr, req_wd;

  int checks = 0;
  int errors = 0;

  data_mem_resp_if bus2();
  data_mem_resp_if bus0();

  assign bus2.mem_read_M   = req_rd & ~sel;
  assign bus2.mem_write_M  = req_wr & ~sel;
  assign bus2.alu_out_M    = req_addr;
  assign bus2.write_data_M = req_wd;
  assign bus0.mem_read_M   = req_rd & sel;
  assign bus0.mem_write_M  = req_wr & sel;
  assign bus0.alu_out_M    = req_addr;
  assign bus0.write_data_M = req_wd;

  data_mem_resp #(.WAIT_STATES(2), .ADDR_WIDTH(10)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  data_mem_resp #(.WAIT_STATES(0), .ADDR_WIDTH(10)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  logic        cur_ack, cur_berr;
  logic [31:0] cur_rdata;
  assign cur_ack   = sel ? bus0.data_mem_ack_M : bus2.data_mem_ack_M;
  assign cur_berr  = sel ? bus0.bus_err        : bus2.bus_err;
  assign cur_rdata = sel ? bus0.read_data_M    : bus2.read_data_M;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: word-addressed memory per DUT, last load value, sticky error.
  logic [31:0] mdl_mem2 [int];
  logic [31:0] mdl_mem0 [int];
  logic [31:0] mdl_rd  [2];
  logic        mdl_err [2];

  function automatic int exp_lat(input logic s);
    return s ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mdl_rd[i]  = 32'h0;
      mdl_err[i] = 1'b0;
    end
  endtask

  task automatic model_op(input logic s, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd);
    bit oor;
    int idx;
    oor = addr >= 32'd4096;
    idx = int'((addr % 32'd4096) / 32'd4);
    if (wr) begin
      if (!oor) begin
        if (s) mdl_mem0[idx] = wd;
        else   mdl_mem2[idx] = wd;
      end
    end else if (rd) begin
      if (oor)    mdl_rd[s] = 32'h0;
      else if (s) mdl_rd[s] = mdl_mem0[idx];
      else        mdl_rd[s] = mdl_mem2[idx];
    end
    if (oor) mdl_err[s] = 1'b1;
  endtask

  // Drives one access, holds it until ack, and reports latency in cycles.
  task automatic run_access(input logic s, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wd, input bit now,
                            output int lat, output logic [31:0] rdata, output logic berr);
    if (!now) @(negedge clk);
    sel = s; req_rd = rd; req_wr = wr; req_addr = addr; req_wd = wd;
    model_op(s, rd, wr, addr, wd);
    lat = -1; rdata = 'x; berr = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (cur_ack === 1'b1) begin
        lat = n; rdata = cur_rdata; berr = cur_berr;
        break;
      end
    end
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic be;
    reset = 1'b1; sel = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus2.data_mem_ack_M !== 1'b0) begin errors++; $display("FAIL reset_ack2: got %b expected 0", bus2.data_mem_ack_M); end
    checks++; if (bus2.read_data_M !== 32'h0) begin errors++; $display("FAIL reset_rdata2: got %h expected 0", bus2.read_data_M); end
    checks++; if (bus2.bus_err !== 1'b0) begin errors++; $display("FAIL reset_berr2: got %b expected 0", bus2.bus_err); end
    checks++; if (bus0.data_mem_ack_M !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", bus0.data_mem_ack_M); end
    checks++; if (bus0.read_data_M !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", bus0.read_data_M); end
    checks++; if (bus0.bus_err !== 1'b0) begin errors++; $display("FAIL reset_berr0: got %b expected 0", bus0.bus_err); end
    reset = 1'b0;
    run_access(1'b0, 1'b0, 1'b1, 32'h40, $urandom, 1'b1, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL first_after_reset_lat: got %0d expected 3", lat); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic be;
    run_access(1'b0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b0, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_lat: got %0d expected 3", lat); end
    checks++; if (be !== 1'b0) begin errors++; $display("FAIL store_berr: got %b expected 0", be); end
    run_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL load_data: got %h expected 12345678", rd); end
    checks++; if (be !== 1'b0) begin errors++; $display("FAIL load_berr: got %b expected 0", be); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic be;
    logic [31:0] v0, v1;
    v0 = $urandom; v1 = $urandom;
    run_access(1'b1, 1'b0, 1'b1, 32'h0, v0, 1'b0, lat, rd, be);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_store0_lat: got %0d expected 1", lat); end
    run_access(1'b1, 1'b0, 1'b1, 32'h4, v1, 1'b0, lat, rd, be);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_store1_lat: got %0d expected 1", lat); end
    @(negedge clk);
    sel = 1'b1; req_rd = 1'b1; req_addr = 32'h0;
    model_op(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus0.data_mem_ack_M !== 1'b1 || bus0.read_data_M !== v0) begin errors++; $display("FAIL b2b_first: ack %b data %h expected ack 1 data %h", bus0.data_mem_ack_M, bus0.read_data_M, v0); end
    req_addr = 32'h4;
    model_op(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    checks++; if (bus0.data_mem_ack_M !== 1'b0) begin errors++; $display("FAIL b2b_gap: ack %b expected 0", bus0.data_mem_ack_M); end
    @(negedge clk);
    checks++; if (bus0.data_mem_ack_M !== 1'b1 || bus0.read_data_M !== v1) begin errors++; $display("FAIL b2b_second: ack %b data %h expected ack 1 data %h", bus0.data_mem_ack_M, bus0.read_data_M, v1); end
    req_rd = 1'b0;
    @(negedge clk);
    checks++; if (bus0.data_mem_ack_M !== 1'b0 || bus0.read_data_M !== v1) begin errors++; $display("FAIL b2b_hold: ack %b data %h expected ack 0 data %h", bus0.data_mem_ack_M, bus0.read_data_M, v1); end
  endtask

  task automatic test_low_bits();
    int lat; logic [31:0] rd; logic be;
    run_access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b0, lat, rd, be);
    run_access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lowbits_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL lowbits_data: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_both_ops();
    int lat; logic [31:0] rd; logic be;
    run_access(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL both_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL both_rdata_kept: got %h expected 0badf00d", rd); end
    repeat (2) @(negedge clk);
    checks++; if (bus2.read_data_M !== 32'h0BAD_F00D) begin errors++; $display("FAIL both_rdata_after: got %h expected 0badf00d", bus2.read_data_M); end
    run_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, be);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_stored: got %h expected cafef00d", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic be;
    run_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h1357_9BDF, 1'b0, lat, rd, be);
    checks++; if (be !== 1'b0) begin errors++; $display("FAIL oor_pre_berr: got %b expected 0", be); end
    run_access(1'b0, 1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 1'b0, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_store_lat: got %0d expected 3", lat); end
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL oor_store_berr: got %b expected 1", be); end
    repeat (3) @(negedge clk);
    checks++; if (bus2.bus_err !== 1'b1) begin errors++; $display("FAIL oor_berr_sticky: got %b expected 1", bus2.bus_err); end
    checks++; if (bus0.bus_err !== 1'b0) begin errors++; $display("FAIL oor_other_berr: got %b expected 0", bus0.bus_err); end
    run_access(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, lat, rd, be);
    checks++; if (lat !== 3 || rd !== 32'h0) begin errors++; $display("FAIL oor_load: lat %0d data %h expected lat 3 data 0", lat, rd); end
    run_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, lat, rd, be);
    checks++; if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL oor_mem_unchanged: got %h expected 13579bdf", rd); end
  endtask

  task automatic test_abort_reset();
    int lat; logic [31:0] rd; logic be;
    bit saw_ack;
    run_access(1'b0, 1'b0, 1'b1, 32'h8, 32'hAAAA_AAAA, 1'b0, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_pre_lat: got %0d expected 3", lat); end
    @(negedge clk);
    sel = 1'b0; req_wr = 1'b1; req_addr = 32'h8; req_wd = 32'h5555_5555;
    @(negedge clk);
    reset = 1'b1; req_wr = 1'b0;
    saw_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus2.data_mem_ack_M !== 1'b0) saw_ack = 1'b1;
    end
    checks++; if (saw_ack) begin errors++; $display("FAIL abort_no_ack: got ack 1 expected 0"); end
    checks++; if (bus2.bus_err !== 1'b0) begin errors++; $display("FAIL abort_berr_cleared: got %b expected 0", bus2.bus_err); end
    model_reset();
    reset = 1'b0;
    run_access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, lat, rd, be);
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_post_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hAAAA_AAAA) begin errors++; $display("FAIL abort_mem_kept: got %h expected aaaaaaaa", rd); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic be;
    logic s;
    logic [31:0] addr;
    bit r, w;
    int op;
    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < 2; d++) begin
        run_access(d[0], 1'b0, 1'b1, 32'h100 + 32'(4 * k), $urandom, 1'b0, lat, rd, be);
      end
    end
    for (int i = 0; i < 40; i++) begin
      s    = 1'($urandom_range(0, 1));
      op   = $urandom_range(0, 9);
      addr = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      r = (op >= 4 && op <= 8) || (op == 9 && $urandom_range(0, 1) == 1);
      w = (op <= 3) || (op == 8) || (op == 9 && !r);
      if (op == 9) addr = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 4095));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_access(s, r, w, addr, $urandom, 1'b0, lat, rd, be);
      checks++; if (lat !== exp_lat(s)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", i, lat, exp_lat(s)); end
      checks++; if (rd !== mdl_rd[s]) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rd, mdl_rd[s]); end
      checks++; if (be !== mdl_err[s]) begin errors++; $display("FAIL rand_berr[%0d]: got %b expected %b", i, be, mdl_err[s]); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_low_bits();
    test_both_ops();
    test_out_of_range();
    test_abort_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
